// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction memory and
// fills the IF/ID register; handles stall, flush, redirects and a BOOT/RUN/HALT machine.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        FLUSH,
    input  logic        HALT_REQ,
    input  logic [1:0]  PC_SRC,
    input  logic [15:0] BRANCH_TGT,
    input  logic [15:0] JUMP_TGT,
    input  logic [15:0] RET_TGT,
    output logic [15:0] IMEM_ADDR,
    input  logic [15:0] IMEM_RD,
    output logic [15:0] IF_ID_INSTR,
    output logic [15:0] IF_ID_PC,
    output logic [15:0] IF_ID_PC_PLUS1,
    output logic        IF_ID_VALID,
    output logic        HALTED,
    output logic        PC_FAULT,
    output logic [15:0] FETCH_COUNT
);

    localparam logic [16:0] DEPTH_L = 17'(IMEM_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t      state_reg;
    logic [15:0] pc_reg;
    logic [15:0] pc_next;
    logic [15:0] pc_plus1;
    logic [15:0] redirect_tgt;
    logic        redirect;
    logic        out_of_range;
    logic        bubble_next;
    logic        load_next;
    logic        halt_next;
    logic        fault_next;

    assign IMEM_ADDR = pc_reg;

    always_comb begin
        pc_plus1     = pc_reg + 16'd1;
        redirect     = (PC_SRC != 2'b00);
        out_of_range = ({1'b0, pc_reg} >= DEPTH_L);
        case (PC_SRC)
            2'b01:   redirect_tgt = BRANCH_TGT;
            2'b10:   redirect_tgt = JUMP_TGT;
            2'b11:   redirect_tgt = RET_TGT;
            default: redirect_tgt = pc_plus1;
        endcase
    end

    // Next-cycle decisions; redirect outranks stall, a stalled or redirected cycle never faults.
    always_comb begin
        pc_next     = pc_reg;
        bubble_next = 1'b0;
        load_next   = 1'b0;
        halt_next   = 1'b0;
        fault_next  = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                bubble_next = 1'b1;
            end
            ST_RUN: begin
                halt_next = HALT_REQ;
                if (redirect) begin
                    pc_next     = redirect_tgt;
                    bubble_next = 1'b1;
                end else if (STALL) begin
                    bubble_next = FLUSH;
                end else if (out_of_range) begin
                    bubble_next = 1'b1;
                    fault_next  = 1'b1;
                    halt_next   = 1'b1;
                end else begin
                    pc_next     = pc_plus1;
                    bubble_next = FLUSH;
                    load_next   = ~FLUSH;
                end
            end
            default: begin
                bubble_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= ST_BOOT;
            pc_reg         <= RESET_PC;
            IF_ID_INSTR    <= NOP_INSTR;
            IF_ID_PC       <= 16'h0000;
            IF_ID_PC_PLUS1 <= 16'h0000;
            IF_ID_VALID    <= 1'b0;
            HALTED         <= 1'b0;
            PC_FAULT       <= 1'b0;
            FETCH_COUNT    <= 16'h0000;
        end else begin
            pc_reg <= pc_next;
            if (bubble_next) begin
                IF_ID_INSTR    <= NOP_INSTR;
                IF_ID_PC       <= pc_reg;
                IF_ID_PC_PLUS1 <= pc_plus1;
                IF_ID_VALID    <= 1'b0;
            end else if (load_next) begin
                IF_ID_INSTR    <= IMEM_RD;
                IF_ID_PC       <= pc_reg;
                IF_ID_PC_PLUS1 <= pc_plus1;
                IF_ID_VALID    <= 1'b1;
                FETCH_COUNT    <= FETCH_COUNT + 16'd1;
            end
            if (fault_next) begin
                PC_FAULT <= 1'b1;
            end
            case (state_reg)
                ST_BOOT: state_reg <= ST_RUN;
                ST_RUN: begin
                    if (halt_next) begin
                        state_reg <= ST_HALT;
                        HALTED    <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_HALT;
                    HALTED    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked against
// a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        halt_req;
    logic [1:0]  pc_src;
    logic [15:0] branch_tgt;
    logic [15:0] jump_tgt;
    logic [15:0] ret_tgt;
    logic [15:0] imem_addr;
    logic [15:0] imem_rd;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        halted;
    logic        pc_fault;
    logic [15:0] fetch_count;

    logic [15:0] imem [64];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] m_pc, m_instr, m_ifpc, m_ifpc1, m_count;
    logic        m_valid, m_halted, m_fault, m_boot;

    fetch_stage dut (
        .CLK(clk), .RST_N(rst_n), .STALL(stall), .FLUSH(flush), .HALT_REQ(halt_req),
        .PC_SRC(pc_src), .BRANCH_TGT(branch_tgt), .JUMP_TGT(jump_tgt), .RET_TGT(ret_tgt),
        .IMEM_ADDR(imem_addr), .IMEM_RD(imem_rd), .IF_ID_INSTR(if_id_instr),
        .IF_ID_PC(if_id_pc), .IF_ID_PC_PLUS1(if_id_pc_plus1), .IF_ID_VALID(if_id_valid),
        .HALTED(halted), .PC_FAULT(pc_fault), .FETCH_COUNT(fetch_count)
    );

    assign imem_rd = (imem_addr < 16'd64) ? imem[imem_addr[5:0]] : 16'hBAD0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = 16'h0000; m_ifpc = 16'h0000; m_ifpc1 = 16'h0000;
        m_count = 16'h0000; m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_boot = 1'b1;
    endtask

    task automatic model_bubble();
        m_instr = 16'h0000; m_valid = 1'b0; m_ifpc = m_pc; m_ifpc1 = m_pc + 16'd1;
    endtask

    // One clock of the fetch rules, applied to the pre-edge model state and current inputs.
    task automatic model_step();
        logic [15:0] tgt;
        tgt = (pc_src == 2'd1) ? branch_tgt : (pc_src == 2'd2) ? jump_tgt : ret_tgt;
        if (m_boot) begin
            model_bubble();
            m_boot = 1'b0;
        end else if (m_halted) begin
            model_bubble();
        end else if (pc_src != 2'd0) begin
            model_bubble();
            m_pc = tgt;
            if (halt_req) m_halted = 1'b1;
        end else if (stall) begin
            if (flush) model_bubble();
            if (halt_req) m_halted = 1'b1;
        end else if (m_pc >= 16'd64) begin
            model_bubble();
            m_fault = 1'b1;
            m_halted = 1'b1;
        end else begin
            if (flush) begin
                model_bubble();
            end else begin
                m_instr = imem[m_pc[5:0]]; m_valid = 1'b1;
                m_ifpc = m_pc; m_ifpc1 = m_pc + 16'd1;
                m_count = m_count + 16'd1;
            end
            m_pc = m_pc + 16'd1;
            if (halt_req) m_halted = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        stall = 1'b0; flush = 1'b0; halt_req = 1'b0; pc_src = 2'd0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
        total++; if (if_id_instr !== 16'h0000) begin bad++; $display("FAIL reset_instr got=%h exp=0000", if_id_instr); end
        total++; if ({if_id_valid, halted, pc_fault} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {if_id_valid, halted, pc_fault}); end
        total++; if (fetch_count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        $display("test_reset: checked reset values");
    endtask

    task automatic test_sequential();
        logic [15:0] seq [4];
        seq[0] = 16'hA001; seq[1] = 16'hA002; seq[2] = 16'hA003; seq[3] = 16'hA004;
        for (int i = 0; i < 4; i++) imem[i] = seq[i];
        do_reset();
        step();
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL boot_valid got=%b exp=0", if_id_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (if_id_instr !== seq[i]) begin bad++; $display("FAIL seq_instr%0d got=%h exp=%h", i, if_id_instr, seq[i]); end
            total++; if (if_id_pc !== 16'(i) || if_id_pc_plus1 !== 16'(i + 1)) begin bad++; $display("FAIL seq_pc%0d got=%0d/%0d exp=%0d/%0d", i, if_id_pc, if_id_pc_plus1, i, i + 1); end
            total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d got=%b exp=1", i, if_id_valid); end
            $display("test_sequential: fetch %0d instr=%h pc=%0d", i, if_id_instr, if_id_pc);
        end
        total++; if (fetch_count !== 16'd3) begin bad++; $display("FAIL seq_count got=%0d exp=3", fetch_count); end
    endtask

    task automatic test_stall();
        step(); step();
        total++; if (imem_addr !== 16'd5) begin bad++; $display("FAIL stall_start_pc got=%0d exp=5", imem_addr); end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (imem_addr !== 16'd5) begin bad++; $display("FAIL stall_pc%0d got=%0d exp=5", i, imem_addr); end
            total++; if (if_id_pc !== 16'd4 || if_id_instr !== imem[4] || if_id_valid !== 1'b1) begin bad++; $display("FAIL stall_ifid%0d got=%0d/%h/%b exp=4/%h/1", i, if_id_pc, if_id_instr, if_id_valid, imem[4]); end
            total++; if (fetch_count !== 16'd5) begin bad++; $display("FAIL stall_count%0d got=%0d exp=5", i, fetch_count); end
            $display("test_stall: cycle %0d pc=%0d count=%0d", i, imem_addr, fetch_count);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (imem_addr !== 16'd5 || if_id_valid !== 1'b0) begin bad++; $display("FAIL stall_flush got=%0d/%b exp=5/0", imem_addr, if_id_valid); end
        $display("test_stall: flush during stall pc=%0d valid=%b", imem_addr, if_id_valid);
    endtask

    task automatic test_branch();
        pc_src = 2'd1; branch_tgt = 16'd20;
        step();
        total++; if (imem_addr !== 16'd20 || if_id_valid !== 1'b0) begin bad++; $display("FAIL branch_redirect got=%0d/%b exp=20/0", imem_addr, if_id_valid); end
        pc_src = 2'd0; stall = 1'b0;
        step();
        total++; if (if_id_pc !== 16'd20 || if_id_valid !== 1'b1 || if_id_instr !== imem[20]) begin bad++; $display("FAIL branch_fetch got=%0d/%b/%h exp=20/1/%h", if_id_pc, if_id_valid, if_id_instr, imem[20]); end
        $display("test_branch: fetched pc=%0d instr=%h", if_id_pc, if_id_instr);
    endtask

    task automatic test_ret_fault();
        pc_src = 2'd3; ret_tgt = 16'd63;
        step();
        total++; if (imem_addr !== 16'd63) begin bad++; $display("FAIL ret_pc got=%0d exp=63", imem_addr); end
        pc_src = 2'd0;
        step();
        total++; if (if_id_pc !== 16'd63 || if_id_valid !== 1'b1 || pc_fault !== 1'b0) begin bad++; $display("FAIL ret_fetch63 got=%0d/%b/%b exp=63/1/0", if_id_pc, if_id_valid, pc_fault); end
        step();
        total++; if ({pc_fault, halted, if_id_valid} !== 3'b110 || imem_addr !== 16'd64) begin bad++; $display("FAIL ret_fault got=%b pc=%0d exp=110 pc=64", {pc_fault, halted, if_id_valid}, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            pc_src = 2'($urandom_range(0, 3)); flush = 1'($urandom_range(0, 1));
            branch_tgt = 16'd2; jump_tgt = 16'd3; ret_tgt = 16'd4;
            step();
            total++; if (imem_addr !== 16'd64 || if_id_valid !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL ret_frozen%0d got=%0d/%b/%b exp=64/0/1", i, imem_addr, if_id_valid, halted); end
            $display("test_ret_fault: halted cycle %0d pc=%0d", i, imem_addr);
        end
        pc_src = 2'd0; flush = 1'b0;
    endtask

    task automatic test_halt_req();
        do_reset();
        for (int i = 0; i < 8; i++) step();
        total++; if (imem_addr !== 16'd7) begin bad++; $display("FAIL halt_start_pc got=%0d exp=7", imem_addr); end
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        total++; if (halted !== 1'b1 || imem_addr !== 16'd8 || if_id_pc !== 16'd7 || if_id_valid !== 1'b1) begin bad++; $display("FAIL halt_enter got=%b/%0d/%0d/%b exp=1/8/7/1", halted, imem_addr, if_id_pc, if_id_valid); end
        pc_src = 2'd2; jump_tgt = 16'd3; flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (imem_addr !== 16'd8 || if_id_valid !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL halt_hold%0d got=%0d/%b/%b exp=8/0/1", i, imem_addr, if_id_valid, halted); end
            $display("test_halt_req: halted cycle %0d pc=%0d", i, imem_addr);
        end
        pc_src = 2'd0; flush = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step();
        #2 rst_n = 1'b0;
        #1;
        total++; if (imem_addr !== 16'h0000 || if_id_instr !== 16'h0000 || if_id_pc !== 16'h0000 || if_id_pc_plus1 !== 16'h0000) begin bad++; $display("FAIL async_words got=%0d/%h/%0d/%0d exp=0/0/0/0", imem_addr, if_id_instr, if_id_pc, if_id_pc_plus1); end
        total++; if ({if_id_valid, halted, pc_fault} !== 3'b000 || fetch_count !== 16'h0000) begin bad++; $display("FAIL async_flags got=%b/%0d exp=000/0", {if_id_valid, halted, pc_fault}, fetch_count); end
        $display("test_async_reset: mid-cycle reset pc=%0d count=%0d", imem_addr, fetch_count);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
            stall      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 6) == 0);
            halt_req   = ($urandom_range(0, 39) == 0);
            pc_src     = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
            branch_tgt = 16'($urandom_range(0, 70));
            jump_tgt   = 16'($urandom_range(0, 70));
            ret_tgt    = 16'($urandom_range(0, 70));
            step();
            total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%0d exp=%0d", i, imem_addr, m_pc); end
            total++; if (if_id_instr !== m_instr || if_id_valid !== m_valid) begin bad++; $display("FAIL rnd_ifid cyc=%0d got=%h/%b exp=%h/%b", i, if_id_instr, if_id_valid, m_instr, m_valid); end
            total++; if (if_id_pc !== m_ifpc || if_id_pc_plus1 !== m_ifpc1) begin bad++; $display("FAIL rnd_ifpc cyc=%0d got=%0d/%0d exp=%0d/%0d", i, if_id_pc, if_id_pc_plus1, m_ifpc, m_ifpc1); end
            total++; if (halted !== m_halted || pc_fault !== m_fault) begin bad++; $display("FAIL rnd_status cyc=%0d got=%b/%b exp=%b/%b", i, halted, pc_fault, m_halted, m_fault); end
            total++; if (fetch_count !== m_count) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, fetch_count, m_count); end
            $display("test_random: cyc=%0d pc=%0d instr=%h valid=%b halted=%b count=%0d", i, imem_addr, if_id_instr, if_id_valid, halted, fetch_count);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; halt_req = 1'b0; pc_src = 2'd0;
        branch_tgt = 16'h0000; jump_tgt = 16'h0000; ret_tgt = 16'h0000;
        for (int i = 0; i < 64; i++) imem[i] = 16'($urandom_range(1, 16'hFFFF));
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_ret_fault();
        test_halt_req();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
